apb_wait_slave: RTL and testbench

//  APB3 completer on the downstream side of the AHB-to-APB sync bridge; consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA.

---
 rtl/apb_wait_slave_pkg.sv | 16 +
 rtl/apb_wait_slave_if.sv | 35 +++
 rtl/apb_wait_slave_regbank.sv | 86 ++++++++
 rtl/apb_wait_slave.sv | 103 ++++++++++
 tb/tb_apb_wait_slave.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/apb_wait_slave_pkg.sv
// rtl/apb_wait_slave_pkg.sv - shared types and constants for the APB wait-state completer
// Optional feature macro: APB4_PSTRB_EN (byte-strobe writes).
package apb_wait_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int CTRL_IDX = 0;
    localparam int ID_IDX   = 1;
    localparam int RAM_BASE = 2;
    localparam int WAIT_W   = 4;

endpackage

// File: rtl/apb_wait_slave_if.sv
// rtl/apb_wait_slave_if.sv - APB3 bus bundle between bridge (master) and completer (slave)
// Signals: psel, penable, paddr, pwrite, pwdata, [pstrb], prdata, pready, pslverr.
// Optional feature macro: APB4_PSTRB_EN adds pstrb.
interface apb_wait_slave_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
`ifdef APB4_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;
`endif
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
`ifdef APB4_PSTRB_EN
        output pstrb,
`endif
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
`ifdef APB4_PSTRB_EN
        input  pstrb,
`endif
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_wait_slave_regbank.sv
// rtl/apb_wait_slave_regbank.sv - CTRL/ID/RAM storage, address decode, strobe merge, error flag, read mux
// Ports: clk, rst (sync, high), we (commit strobe), addr/write (latched access),
//        wdata, [strb], err (access would fault), rdata (0 on error), wait_n (CTRL.WAIT_N).
// Optional feature macro: APB4_PSTRB_EN (per-lane write enables from strb).
module apb_wait_slave_regbank
    import apb_wait_slave_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 12,
    parameter int          DEPTH    = 16,
    parameter logic [3:0]  DEF_WAIT = 4'd0,
    parameter logic [31:0] ID_VALUE = 32'hA5B2_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic [DATA_W-1:0] wdata,
`ifdef APB4_PSTRB_EN
    input  logic [DATA_W/8-1:0] strb,
`endif
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [WAIT_W-1:0] wait_n
);
    localparam int RAM_N  = DEPTH - RAM_BASE;
    localparam int RAM_AW = (RAM_N > 1) ? $clog2(RAM_N) : 1;

    logic [DATA_W-1:0] ram [RAM_N];

    logic [31:0]       idx;
    logic              oob;
    logic              is_ctrl;
    logic              is_id;
    logic              is_ram;
    logic [RAM_AW-1:0] ram_off;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] merged;

    assign idx     = 32'(addr[ADDR_W-1:2]);
    assign oob     = idx >= 32'(DEPTH);
    assign is_ctrl = idx == 32'(CTRL_IDX);
    assign is_id   = idx == 32'(ID_IDX);
    assign is_ram  = !oob && (idx >= 32'(RAM_BASE));
    assign ram_off = RAM_AW'(idx - 32'(RAM_BASE));

    assign err = (addr[1:0] != 2'b00) || oob || (write && is_id);

    // Unmasked current word; also the base for strobe merging.
    always_comb begin
        raw = '0;
        if (is_ctrl)
            raw = DATA_W'(wait_n);
        else if (is_id)
            raw = ID_VALUE[DATA_W-1:0];
        else if (is_ram)
            raw = ram[ram_off];
    end

    assign rdata = err ? '0 : raw;

`ifdef APB4_PSTRB_EN
    always_comb begin
        merged = raw;
        for (int i = 0; i < DATA_W/8; i++)
            if (strb[i])
                merged[8*i +: 8] = wdata[8*i +: 8];
    end
`else
    assign merged = wdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_n <= DEF_WAIT;
            for (int i = 0; i < RAM_N; i++)
                ram[i] <= '0;
        end else if (we && !err) begin
            if (is_ctrl)
                wait_n <= merged[WAIT_W-1:0];
            else if (is_ram)
                ram[ram_off] <= merged;
        end
    end
endmodule

// File: rtl/apb_wait_slave.sv
// rtl/apb_wait_slave.sv - APB3 completer with register bank and programmable PREADY wait states
// Ports: pclk, preset (sync, active-high), pclken (state advances only when 1),
//        apb (slave modport: psel/penable/paddr/pwrite/pwdata/[pstrb] in, prdata/pready/pslverr out).
// Optional feature macro: APB4_PSTRB_EN (byte-strobe writes).
module apb_wait_slave
    import apb_wait_slave_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 12,
    parameter int          DEPTH    = 16,
    parameter logic [3:0]  DEF_WAIT = 4'd0,
    parameter logic [31:0] ID_VALUE = 32'hA5B2_0001
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic            pclken,
    apb_wait_slave_if.slave apb
);
    state_t            state, state_n;
    logic [WAIT_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              write_q, write_n;
    logic [WAIT_W-1:0] wait_n;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              we;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else if (pclken) begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr_q  <= addr_n;
            write_q <= write_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        write_n = write_q;
        we      = 1'b0;
        case (state)
            IDLE: begin
                // A stray access phase (penable without setup) is ignored.
                if (apb.psel && !apb.penable) begin
                    addr_n  = apb.paddr;
                    write_n = apb.pwrite;
                    if (wait_n == '0) begin
                        state_n = READY;
                    end else begin
                        cnt_n   = wait_n;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!apb.psel)
                    state_n = IDLE;
                else if (cnt == WAIT_W'(1))
                    state_n = READY;
                else
                    cnt_n = cnt - WAIT_W'(1);
            end
            READY: begin
                state_n = IDLE;
                we      = pclken && apb.psel && write_q;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs depend only on registered state and the latched address.
    assign apb.pready  = (state == READY);
    assign apb.pslverr = (state == READY) && err;
    assign apb.prdata  = ((state == READY) && !write_q) ? rdata : '0;

    apb_wait_slave_regbank #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .DEF_WAIT (DEF_WAIT),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk    (pclk),
        .rst    (preset),
        .we     (we),
        .addr   (addr_q),
        .write  (write_q),
        .wdata  (apb.pwdata),
`ifdef APB4_PSTRB_EN
        .strb   (apb.pstrb),
`endif
        .err    (err),
        .rdata  (rdata),
        .wait_n (wait_n)
    );
endmodule

// File: tb/tb_apb_wait_slave.sv
// tb/tb_apb_wait_slave.sv - directed scoreboard bench for apb_wait_slave
// Optional feature macro: APB4_PSTRB_EN enables the strobe steps.
module tb_apb_wait_slave;
    logic       pclk      = 1'b0;
    logic       preset    = 1'b1;
    logic       pclken    = 1'b1;
    logic       toggle_en = 1'b0;
    logic [3:0] wstrb     = 4'hF;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          id;
        logic        rd;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb[$];

    apb_wait_slave_if bus ();

    apb_wait_slave dut (
        .pclk   (pclk),
        .preset (preset),
        .pclken (pclken),
        .apb    (bus)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        #1;
        pclken = toggle_en ? ~pclken : 1'b1;
    end

    task automatic check(input int id, input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s step%0d observed=%h expected=%h", name, id, obs, exp);
    endtask

    // Advance to the next clock edge that the DUT actually samples with pclken=1.
    task automatic step_en();
        int g = 0;
        do begin
            @(posedge pclk);
            g++;
        end while (!pclken && g < 8);
    endtask

    task automatic xfer(input int id, input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
        exp_t        e;
        int          waits = 0;
        bit          done  = 0;
        logic        prev_en = 1'b1;
        logic        prev_rdy = 1'b0;
        logic [31:0] prev_data = '0;
        e.id = id; e.rd = !wr; e.rdata = exp_rd; e.err = exp_err; e.waits = exp_waits;
        sb.push_back(e);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wd;
`ifdef APB4_PSTRB_EN
        bus.pstrb = wstrb;
`endif
        step_en();
        #1 bus.penable = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge pclk);
            if (i > 0 && !prev_en) begin
                check(id, "hold_pready", bus.pready, prev_rdy);
                check(id, "hold_prdata", bus.prdata, prev_data);
            end
            if (pclken) begin
                if (bus.pready) done = 1;
                else waits++;
            end
            prev_en = pclken; prev_rdy = bus.pready; prev_data = bus.prdata;
        end
        e = sb.pop_front();
        check(e.id, "complete", 32'(done), 32'd1);
        check(e.id, "waits", waits, e.waits);
        check(e.id, "pslverr", bus.pslverr, 32'(e.err));
        if (e.rd) check(e.id, "prdata", bus.prdata, e.rdata);
        @(posedge pclk);
        #1 bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0; bus.pwdata = '0;
`ifdef APB4_PSTRB_EN
        bus.pstrb = 4'hF;
`endif
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        check(0, "rst_pready", bus.pready, 0);
        check(0, "rst_pslverr", bus.pslverr, 0);
        check(0, "rst_prdata", bus.prdata, 0);
        @(posedge pclk); #1;

        xfer(1,  12'h008, 1, 32'hDEADBEEF, 32'h0,          0, 0);
        xfer(2,  12'h008, 0, 32'h0,        32'hDEADBEEF,   0, 0);
        xfer(3,  12'h000, 1, 32'h3,        32'h0,          0, 0);
        xfer(4,  12'h008, 0, 32'h0,        32'hDEADBEEF,   0, 3);
        xfer(5,  12'h000, 1, 32'h1,        32'h0,          0, 3);
        xfer(6,  12'h000, 0, 32'h0,        32'h1,          0, 1);
        xfer(7,  12'h000, 1, 32'h0,        32'h0,          0, 1);
        xfer(8,  12'h004, 0, 32'h0,        32'hA5B20001,   0, 0);
        xfer(9,  12'h004, 1, 32'h1,        32'h0,          1, 0);
        xfer(10, 12'h004, 0, 32'h0,        32'hA5B20001,   0, 0);
        xfer(11, 12'h040, 0, 32'h0,        32'h0,          1, 0);
        xfer(12, 12'h00A, 0, 32'h0,        32'h0,          1, 0);
        xfer(13, 12'h009, 1, 32'h0000FFFF, 32'h0,          1, 0);
        xfer(14, 12'h008, 0, 32'h0,        32'hDEADBEEF,   0, 0);
        xfer(15, 12'h03C, 0, 32'h0,        32'h0,          0, 0);
        xfer(16, 12'h03C, 1, 32'h000055AA, 32'h0,          0, 0);
        xfer(17, 12'h03C, 0, 32'h0,        32'h000055AA,   0, 0);
        xfer(18, 12'h000, 1, 32'hFFFFFFF2, 32'h0,          0, 0);
        xfer(19, 12'h000, 0, 32'h0,        32'h2,          0, 2);

        toggle_en = 1'b1;
        xfer(20, 12'h008, 0, 32'h0,        32'hDEADBEEF,   0, 2);
        toggle_en = 1'b0;
        xfer(21, 12'h000, 1, 32'h3,        32'h0,          0, 2);

        // Reset pulse while a write to 0x00C sits in WAIT.
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 12'h00C; bus.pwrite = 1'b1; bus.pwdata = 32'h1234;
        @(posedge pclk); #1 bus.penable = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check(22, "wait_pready", bus.pready, 0);
        preset = 1'b1;
        @(posedge pclk);
        #1 preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge pclk);
        check(22, "prst_pready", bus.pready, 0);
        check(22, "prst_pslverr", bus.pslverr, 0);
        check(22, "prst_prdata", bus.prdata, 0);
        @(posedge pclk); #1;
        xfer(23, 12'h00C, 0, 32'h0,        32'h0,          0, 0);
        xfer(24, 12'h008, 0, 32'h0,        32'h0,          0, 0);

`ifdef APB4_PSTRB_EN
        wstrb = 4'b0101;
        xfer(25, 12'h00C, 1, 32'hFFFFFFFF, 32'h0,          0, 0);
        xfer(26, 12'h00C, 0, 32'h0,        32'h00FF00FF,   0, 0);
        wstrb = 4'b0000;
        xfer(27, 12'h00C, 1, 32'h12345678, 32'h0,          0, 0);
        xfer(28, 12'h00C, 0, 32'h0,        32'h00FF00FF,   0, 0);
        wstrb = 4'hF;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
